// File: rtl/lzc_norm_arbiter_if.sv
// rtl/lzc_norm_arbiter_if.sv - request/operand and result handshake bundle for lzc_norm_arbiter
interface lzc_norm_arbiter_if;
  logic [1:0]  i_req;
  logic [31:0] i_data0;
  logic [31:0] i_data1;
  logic [7:0]  i_exp0;
  logic [7:0]  i_exp1;
  logic [1:0]  o_gnt;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [7:0]  o_exp;
  logic        o_id;
  logic        o_zero;
  logic        o_underflow;
  logic        o_busy;

  modport slave (
    input  i_req, i_data0, i_data1, i_exp0, i_exp1, i_ready,
    output o_gnt, o_valid, o_data, o_exp, o_id, o_zero, o_underflow, o_busy
  );

  modport master (
    output i_req, i_data0, i_data1, i_exp0, i_exp1, i_ready,
    input  o_gnt, o_valid, o_data, o_exp, o_id, o_zero, o_underflow, o_busy
  );
endinterface

// File: rtl/lzc_norm_arbiter.sv
// rtl/lzc_norm_arbiter.sv - two-requester round-robin leading-zero normalizer
module lzc_norm_arbiter (
  input logic               i_clk,
  input logic               i_rst_n,
  lzc_norm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, SHIFT, OUT} state_t;

  state_t      state;
  // Requester granted most recently; resets to 1 so requester 0 wins the first tie.
  logic        last_id;
  logic [31:0] cap_data;
  logic [7:0]  cap_exp;
  logic        cap_id;
  logic [4:0]  nlz_q;
  logic        zero_q;

  logic [4:0]  lz_cnt;
  logic        lz_zero;
  logic [1:0]  gnt;
  logic        gnt_id;

  logic        valid_q;
  logic [31:0] data_q;
  logic [7:0]  exp_q;
  logic        id_q;
  logic        zero_out_q;
  logic        uf_q;

  // Round-robin grant, only offered in IDLE and never while reset is held.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (state == IDLE && i_rst_n) begin
      case (bus.i_req)
        2'b01: begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
          gnt_id = ~last_id;
          gnt    = last_id ? 2'b01 : 2'b10;
        end
        default: begin
          gnt    = 2'b00;
          gnt_id = 1'b0;
        end
      endcase
    end
  end

  // Leading-zero count of the captured significand; the highest set bit wins.
  always_comb begin
    lz_cnt  = 5'd0;
    lz_zero = (cap_data == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (cap_data[i]) begin
        lz_cnt = 5'(31 - i);
      end
    end
  end

  // Operation sequencer: capture, count, shift, then hold the result until consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_id    <= 1'b1;
      cap_data   <= 32'd0;
      cap_exp    <= 8'd0;
      cap_id     <= 1'b0;
      nlz_q      <= 5'd0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'd0;
      exp_q      <= 8'd0;
      id_q       <= 1'b0;
      zero_out_q <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            cap_data <= gnt_id ? bus.i_data1 : bus.i_data0;
            cap_exp  <= gnt_id ? bus.i_exp1 : bus.i_exp0;
            cap_id   <= gnt_id;
            last_id  <= gnt_id;
            state    <= COUNT;
          end
        end
        COUNT: begin
          nlz_q  <= lz_cnt;
          zero_q <= lz_zero;
          state  <= SHIFT;
        end
        SHIFT: begin
          id_q <= cap_id;
          if (zero_q) begin
            data_q     <= 32'd0;
            exp_q      <= 8'd0;
            zero_out_q <= 1'b1;
            uf_q       <= 1'b0;
          end else if ({3'b000, nlz_q} <= cap_exp) begin
            data_q     <= cap_data << nlz_q;
            exp_q      <= cap_exp - {3'b000, nlz_q};
            zero_out_q <= 1'b0;
            uf_q       <= 1'b0;
          end else begin
            // Exponent is below 32 here, so this shift cannot run off the end.
            data_q     <= cap_data << cap_exp;
            exp_q      <= 8'd0;
            zero_out_q <= 1'b0;
            uf_q       <= 1'b1;
          end
          valid_q <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_exp       = exp_q;
  assign bus.o_id        = id_q;
  assign bus.o_zero      = zero_out_q;
  assign bus.o_underflow = uf_q;

endmodule

// File: tb/tb_lzc_norm_arbiter.sv
// tb/tb_lzc_norm_arbiter.sv - self-checking bench for lzc_norm_arbiter
module tb_lzc_norm_arbiter;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [7:0]  e0;
    logic [31:0] d1;
    logic [7:0]  e1;
    logic [1:0]  gnt;
    logic [31:0] odata;
    logic [7:0]  oexp;
    logic        oid;
    logic        ozero;
    logic        ouf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  exp;
    logic        id;
    logic        zero;
    logic        uf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  res_t exp_q[$];
  vec_t vecs[8];

  lzc_norm_arbiter_if bus ();

  lzc_norm_arbiter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: each completed handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("o_data", bus.o_data, r.data);
        chk("o_exp", {24'd0, bus.o_exp}, {24'd0, r.exp});
        chk("o_id", {31'd0, bus.o_id}, {31'd0, r.id});
        chk("o_zero", {31'd0, bus.o_zero}, {31'd0, r.zero});
        chk("o_underflow", {31'd0, bus.o_underflow}, {31'd0, r.uf});
      end
    end
  end

  task automatic wait_gnt(output logic [1:0] g, output int at_cyc);
    int n;
    n = 0;
    g = 2'b00;
    at_cyc = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.o_gnt != 2'b00) break;
    end
    g = bus.o_gnt;
    at_cyc = cyc;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (bus.o_valid) break;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [1:0] g;
    int         c;
    int         lat;
    res_t       r;
    @(posedge clk);
    #1;
    bus.i_req   = v.req;
    bus.i_data0 = v.d0;
    bus.i_exp0  = v.e0;
    bus.i_data1 = v.d1;
    bus.i_exp1  = v.e1;
    wait_gnt(g, c);
    chk($sformatf("vec%0d_gnt", idx), {30'd0, g}, {30'd0, v.gnt});
    r = '{v.odata, v.oexp, v.oid, v.ozero, v.ouf};
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    bus.i_req   = 2'b00;
    bus.i_data0 = 32'hDEAD_BEEF;
    bus.i_exp0  = 8'hA5;
    bus.i_data1 = 32'h0BAD_F00D;
    bus.i_exp1  = 8'h5A;
    wait_valid(lat);
    chk($sformatf("vec%0d_latency", idx), lat, 32'd3);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_req = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    int         c;
    int         prev_c;
    int         lat;
    int         seen;
    int         n;
    int         order[3];
    res_t       res0;
    res_t       res1;
    logic [31:0] held;

    vecs[0] = '{2'b01, 32'h0000_1234, 8'd100, 32'hFFFF_0000, 8'd7,   2'b01, 32'h91A0_0000, 8'd81,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 32'h5555_5555, 8'd9,   32'h0000_0000, 8'd50,  2'b10, 32'h0000_0000, 8'd0,   1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 32'h0000_0001, 8'd4,   32'h0000_0000, 8'd0,   2'b01, 32'h0000_0010, 8'd0,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 32'h8000_0000, 8'd0,   32'h0000_0001, 8'd1,   2'b01, 32'h8000_0000, 8'd0,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 32'h0000_0000, 8'd0,   32'h0001_0000, 8'd15,  2'b10, 32'h8000_0000, 8'd0,   1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0000, 8'd0,   32'h0001_0000, 8'd14,  2'b10, 32'h4000_0000, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 32'hFFFF_FFFF, 8'd255, 32'h0000_0000, 8'd0,   2'b01, 32'hFFFF_FFFF, 8'd255, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0000, 8'd0,   32'h0000_0003, 8'd200, 2'b10, 32'hC000_0000, 8'd170, 1'b1, 1'b0, 1'b0};

    bus.i_req   = 2'b11;
    bus.i_data0 = 32'h0000_1234;
    bus.i_exp0  = 8'd100;
    bus.i_data1 = 32'h0000_0001;
    bus.i_exp1  = 8'd1;
    bus.i_ready = 1'b1;

    // Reset state, with requests present to show no grant escapes during reset.
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, bus.o_gnt}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_data", bus.o_data, 32'd0);
    chk("rst_exp", {24'd0, bus.o_exp}, 32'd0);
    chk("rst_id", {31'd0, bus.o_id}, 32'd0);
    chk("rst_zero", {31'd0, bus.o_zero}, 32'd0);
    chk("rst_uf", {31'd0, bus.o_underflow}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.i_req = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i], i);
    end

    // Contention: fresh reset so requester 0 leads; grants must go 0, 1, 0 four cycles apart.
    pulse_reset();
    res0 = '{32'hF000_0000, 8'd6, 1'b0, 1'b0, 1'b0};
    res1 = '{32'h8000_0000, 8'd0, 1'b1, 1'b0, 1'b0};
    order[0] = 0;
    order[1] = 1;
    order[2] = 0;
    bus.i_data0 = 32'h0000_00F0;
    bus.i_exp0  = 8'd30;
    bus.i_data1 = 32'h0000_0001;
    bus.i_exp1  = 8'd31;
    bus.i_req   = 2'b11;
    prev_c = 0;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(g, c);
      chk($sformatf("cont%0d_gnt", k), {30'd0, g}, (order[k] == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk($sformatf("cont%0d_spacing", k), c - prev_c, 32'd4);
      prev_c = c;
      exp_q.push_back((order[k] == 0) ? res0 : res1);
      @(posedge clk);
      #1;
      if (k == 1) bus.i_req = 2'b01;
      if (k == 2) bus.i_req = 2'b00;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cont_drained", exp_q.size(), 32'd0);

    // Backpressure: result must hold for 5 cycles with a request pending and no grant.
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    bus.i_req   = 2'b01;
    bus.i_data0 = 32'h0000_0003;
    bus.i_exp0  = 8'd200;
    wait_gnt(g, c);
    chk("bp_gnt", {30'd0, g}, 32'd1);
    exp_q.push_back('{32'hC000_0000, 8'd170, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.i_req = 2'b00;
    wait_valid(lat);
    chk("bp_latency", lat, 32'd3);
    @(posedge clk);
    #1;
    bus.i_req   = 2'b10;
    bus.i_data1 = 32'h0000_0000;
    bus.i_exp1  = 8'd50;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      held = bus.o_data;
      chk($sformatf("bp%0d_valid", k), {31'd0, bus.o_valid}, 32'd1);
      chk($sformatf("bp%0d_data", k), held, 32'hC000_0000);
      chk($sformatf("bp%0d_gnt", k), {30'd0, bus.o_gnt}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_pending_gnt", {30'd0, bus.o_gnt}, 32'd2);
    exp_q.push_back('{32'h0000_0000, 8'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    bus.i_req = 2'b00;
    wait_valid(lat);
    chk("bp_next_latency", lat, 32'd3);

    // Reset while in SHIFT discards the operation.
    @(posedge clk);
    #1;
    bus.i_req   = 2'b01;
    bus.i_data0 = 32'h0000_1234;
    bus.i_exp0  = 8'd100;
    wait_gnt(g, c);
    chk("rs_gnt", {30'd0, g}, 32'd1);
    exp_q.push_back('{32'h91A0_0000, 8'd81, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.i_req = 2'b00;
    @(posedge clk);
    #1;
    chk("rs_busy_before", {31'd0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rs_data", bus.o_data, 32'd0);
    chk("rs_exp", {24'd0, bus.o_exp}, 32'd0);
    chk("rs_id", {31'd0, bus.o_id}, 32'd0);
    chk("rs_zero", {31'd0, bus.o_zero}, 32'd0);
    chk("rs_uf", {31'd0, bus.o_underflow}, 32'd0);
    chk("rs_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rs_gnt0", {30'd0, bus.o_gnt}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_busy) seen++;
    end
    chk("rs_no_result", seen, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
